shifter_operand_unit: RTL and testbench

SHIFTER_OPERAND_UNIT -- requirements
Module: shifter_operand_unit

---
 rtl/shifter_operand_unit.sv | 143 ++++++++++++++
 tb/tb_shifter_operand_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_operand_unit.sv
// ARM-style shifter operand unit: immediate rotate resolves in one edge,
// register shifts iterate one bit per clock through a working register.
module shifter_operand_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_imm,
   input  logic [7:0]  immediate,
   input  logic [3:0]  rotate_imm,
   input  logic [31:0] rm_val,
   input  logic [1:0]  shift_type,
   input  logic [7:0]  shift_amt,
   input  logic        carry_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] operand,
   output logic        carry_out
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   localparam logic [1:0] TypeLsl = 2'b00;
   localparam logic [1:0] TypeLsr = 2'b01;
   localparam logic [1:0] TypeAsr = 2'b10;
   localparam logic [1:0] TypeRor = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] work_q, work_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [1:0]  type_q, type_d;
   logic [31:0] operand_q, operand_d;
   logic        carry_out_q, carry_out_d;

   logic [31:0] imm_ext;
   logic [63:0] imm_rot64;
   logic [31:0] imm_rot;
   logic [5:0]  eff_cnt;
   logic [31:0] shifted;
   logic        shift_carry;
   logic        accept;

   // Rotating a doubled copy keeps the zero-rotate case free of a 32-bit shift.
   always_comb begin
      imm_ext   = {24'h0, immediate};
      imm_rot64 = {imm_ext, imm_ext} >> {rotate_imm, 1'b0};
      imm_rot   = imm_rot64[31:0];
   end

   always_comb begin
      eff_cnt = 6'd0;
      unique case (shift_type)
         TypeLsl, TypeLsr: eff_cnt = (shift_amt > 8'd33) ? 6'd33 : shift_amt[5:0];
         TypeAsr:          eff_cnt = (shift_amt > 8'd32) ? 6'd32 : shift_amt[5:0];
         TypeRor:          eff_cnt = {1'b0, shift_amt[4:0]};
         default:          eff_cnt = 6'd0;
      endcase
   end

   always_comb begin
      shifted     = work_q;
      shift_carry = work_q[0];
      unique case (type_q)
         TypeLsl: begin
            shifted     = {work_q[30:0], 1'b0};
            shift_carry = work_q[31];
         end
         TypeLsr: shifted = {1'b0, work_q[31:1]};
         TypeAsr: shifted = {work_q[31], work_q[31:1]};
         TypeRor: shifted = {work_q[0], work_q[31:1]};
         default: shifted = work_q;
      endcase
   end

   assign accept = start && (state_q != StShift);

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      type_d      = type_q;
      operand_d   = operand_q;
      carry_out_d = carry_out_q;

      case (state_q)
         StShift: begin
            work_d = shifted;
            cnt_d  = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               operand_d   = shifted;
               carry_out_d = shift_carry;
               state_d     = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (accept) begin
         if (is_imm) begin
            operand_d   = imm_rot;
            carry_out_d = (rotate_imm == 4'd0) ? carry_in : imm_rot[31];
            state_d     = StDone;
         end else if (shift_amt == 8'd0) begin
            operand_d   = rm_val;
            carry_out_d = carry_in;
            state_d     = StDone;
         end else if (shift_type == TypeRor && shift_amt[4:0] == 5'd0) begin
            operand_d   = rm_val;
            carry_out_d = rm_val[31];
            state_d     = StDone;
         end else begin
            work_d  = rm_val;
            cnt_d   = eff_cnt;
            type_d  = shift_type;
            state_d = StShift;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         work_q      <= 32'h0;
         cnt_q       <= 6'd0;
         type_q      <= 2'b00;
         operand_q   <= 32'h0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         type_q      <= type_d;
         operand_q   <= operand_d;
         carry_out_q <= carry_out_d;
      end
   end

   assign busy      = (state_q == StShift);
   assign done      = (state_q == StDone);
   assign operand   = operand_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Randomized bench for shifter_operand_unit against an arithmetic ARM-shift model.
module tb_shifter_operand_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_imm;
   logic [7:0]  immediate;
   logic [3:0]  rotate_imm;
   logic [31:0] rm_val;
   logic [1:0]  shift_type;
   logic [7:0]  shift_amt;
   logic        carry_in;
   logic        busy;
   logic        done;
   logic [31:0] operand;
   logic        carry_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] last_op;
   logic        last_c;

   shifter_operand_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_imm     (is_imm),
      .immediate  (immediate),
      .rotate_imm (rotate_imm),
      .rm_val     (rm_val),
      .shift_type (shift_type),
      .shift_amt  (shift_amt),
      .carry_in   (carry_in),
      .busy       (busy),
      .done       (done),
      .operand    (operand),
      .carry_out  (carry_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected result from the architectural shift definitions, plus edges until done.
   function automatic void model(input logic im, input logic [7:0] imm, input logic [3:0] rot,
                                 input logic [31:0] rm, input logic [1:0] st,
                                 input logic [7:0] amt, input logic cin,
                                 output logic [31:0] op, output logic c, output int lat);
      int n;
      int r;
      logic [31:0] x;
      lat = 1;
      n   = int'(amt);
      if (im) begin
         r  = 2 * int'(rot);
         x  = {24'h0, imm};
         op = (r == 0) ? x : ((x >> r) | (x << (32 - r)));
         c  = (rot == 0) ? cin : op[31];
      end else if (n == 0) begin
         op = rm;
         c  = cin;
      end else begin
         case (st)
            2'b00: begin
               lat = ((n > 33) ? 33 : n) + 1;
               if (n < 32) begin op = rm << n; c = rm[32 - n]; end
               else if (n == 32) begin op = 32'h0; c = rm[0]; end
               else begin op = 32'h0; c = 1'b0; end
            end
            2'b01: begin
               lat = ((n > 33) ? 33 : n) + 1;
               if (n < 32) begin op = rm >> n; c = rm[n - 1]; end
               else if (n == 32) begin op = 32'h0; c = rm[31]; end
               else begin op = 32'h0; c = 1'b0; end
            end
            2'b10: begin
               if (n >= 32) begin
                  lat = 33;
                  op  = {32{rm[31]}};
                  c   = rm[31];
               end else begin
                  lat = n + 1;
                  op  = $signed(rm) >>> n;
                  c   = rm[n - 1];
               end
            end
            default: begin
               r = n % 32;
               if (r == 0) begin
                  op = rm;
                  c  = rm[31];
               end else begin
                  lat = r + 1;
                  op  = (rm >> r) | (rm << (32 - r));
                  c   = rm[r - 1];
               end
            end
         endcase
      end
   endfunction

   // Issues one request from the current cycle (idle or done) and waits for done.
   // With noisy set, inputs and start are scrambled while busy; they must be ignored.
   task automatic do_op(input string tag, input logic im, input logic [7:0] imm,
                        input logic [3:0] rot, input logic [31:0] rm, input logic [1:0] st,
                        input logic [7:0] amt, input logic cin, input bit noisy);
      logic [31:0] exp_op;
      logic        exp_c;
      int          exp_lat;
      int          edges;
      int          busy_cyc;
      model(im, imm, rot, rm, st, amt, cin, exp_op, exp_c, exp_lat);
      is_imm = im; immediate = imm; rotate_imm = rot; rm_val = rm;
      shift_type = st; shift_amt = amt; carry_in = cin; start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      edges    = 1;
      busy_cyc = 0;
      while (!done && edges < 60) begin
         if (busy) busy_cyc++;
         if (noisy) begin
            start      = 1'($urandom_range(0, 1));
            rm_val     = $urandom;
            shift_amt  = 8'($urandom);
            shift_type = 2'($urandom);
            is_imm     = 1'($urandom);
            carry_in   = 1'($urandom);
         end
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      check_eq({tag, "_lat"}, 64'(edges), 64'(exp_lat));
      check_eq({tag, "_done"}, 64'(done), 64'd1);
      check_eq({tag, "_busy"}, 64'(busy_cyc), 64'(exp_lat - 1));
      check_eq({tag, "_op"}, 64'(operand), 64'(exp_op));
      check_eq({tag, "_c"}, 64'(carry_out), 64'(exp_c));
      last_op = exp_op;
      last_c  = exp_c;
   endtask

   initial begin
      int done_seen;
      int gap;
      logic [7:0] amt;
      reset = 1'b1; start = 1'b0; is_imm = 1'b0; immediate = 8'h0; rotate_imm = 4'h0;
      rm_val = 32'h0; shift_type = 2'b00; shift_amt = 8'h0; carry_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_op", 64'(operand), 64'd0);
      check_eq("rst_c", 64'(carry_out), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op("imm_rot4", 1'b1, 8'hFF, 4'd4, 32'h0, 2'b00, 8'd0, 1'b0, 1'b0);
      do_op("imm_rot0", 1'b1, 8'hFF, 4'd0, 32'h0, 2'b00, 8'd0, 1'b1, 1'b0);
      do_op("lsr1", 1'b0, 8'h0, 4'd0, 32'h8000_0001, 2'b01, 8'd1, 1'b0, 1'b0);
      do_op("lsl32", 1'b0, 8'h0, 4'd0, 32'h8000_0001, 2'b00, 8'd32, 1'b0, 1'b0);
      do_op("lsl40", 1'b0, 8'h0, 4'd0, 32'h8000_0001, 2'b00, 8'd40, 1'b1, 1'b0);
      do_op("asr200", 1'b0, 8'h0, 4'd0, 32'h8000_0001, 2'b10, 8'd200, 1'b0, 1'b0);
      do_op("ror32", 1'b0, 8'h0, 4'd0, 32'h8000_0001, 2'b11, 8'd32, 1'b0, 1'b0);
      do_op("ror4", 1'b0, 8'h0, 4'd0, 32'h0000_00F1, 2'b11, 8'd4, 1'b1, 1'b1);
      do_op("amt0", 1'b0, 8'h0, 4'd0, 32'h1234_5678, 2'b10, 8'd0, 1'b1, 1'b0);
      // Back-to-back from the done cycle: latency counted from it proves no bubble.
      do_op("b2b", 1'b0, 8'h0, 4'd0, 32'hF000_000F, 2'b01, 8'd3, 1'b0, 1'b0);

      // Reset partway through LSL 20: start is edge 1, reset lands on edge 5.
      is_imm = 1'b0; rm_val = 32'hDEAD_BEEF; shift_type = 2'b00; shift_amt = 8'd20;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_eq("midrst_done", 64'(done), 64'd0);
      check_eq("midrst_op", 64'(operand), 64'd0);
      check_eq("midrst_c", 64'(carry_out), 64'd0);
      done_seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      check_eq("midrst_quiet", 64'(done_seen), 64'd0);

      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 3))
            0:       amt = 8'($urandom_range(0, 8));
            1:       amt = 8'($urandom_range(30, 34));
            2:       amt = 8'($urandom_range(1, 31));
            default: amt = 8'($urandom);
         endcase
         do_op("rnd", 1'($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom), $urandom,
               2'($urandom), amt, 1'($urandom), 1'($urandom));
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            @(posedge clk); #1;
            check_eq("hold_done", 64'(done), 64'd0);
            check_eq("hold_op", 64'(operand), 64'(last_op));
            check_eq("hold_c", 64'(carry_out), 64'(last_c));
            if (gap > 1) begin
               @(posedge clk); #1;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
